aes_unit_arbiter: RTL
=====================

AES_UNIT_ARBITER -- requirements
Module: aes_unit_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  128  state/text width in bits
  TIMEOUT  255  max BUSY cycles awaiting unit ready (1..255)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clk  in  1  single clock, rising edge
  Rst  in  1  asynchronous, active-low reset
  EncEn  in  4  encryptor op request {Mix,Shift,Sub,Add}, level-held
  EncText  in  WIDTH  encryptor operand
  DecEn  in  4  decryptor op request, same encoding
  DecText  in  WIDTH  decryptor operand
  AddEn/SubEn/ShiftEn/MixEn  out  1 each  shared-unit enables
  Text  out  WIDTH  operand to shared units
  AddRy/SubRy/ShiftRy/MixRy  in  1 each  shared-unit ready
  ModifiedText  in  WIDTH  shared-unit result
  EncRy/DecRy  out  1 each  one-cycle completion pulse to requester
  Result  out  WIDTH  captured result, valid with EncRy/DecRy
  Owner  out  1  0=encryptor, 1=decryptor; valid when Busy
  Busy  out  1  high in BUSY and RELEASE
  Err  out  1  one-cycle pulse: illegal op or timeout

Function
REQ-003 FSM SHALL have states IDLE, BUSY, RELEASE.
REQ-004 In IDLE, a requester is active when its En vector is nonzero.
REQ-005 One active requester SHALL be granted; both active: grant the one not in LastOwner (round-robin).
REQ-006 On grant, Owner, op code and operand SHALL be latched; the operand is not re-sampled.
REQ-007 Grant with one-hot op: next cycle BUSY, exactly one unit enable high, Text = latched operand.
REQ-008 Grant with non-one-hot op: Err pulses next cycle, no unit enable, no Ry pulse, state goes to RELEASE.
REQ-009 In BUSY only the ready matching the latched op SHALL be honoured; other readies are ignored.
REQ-010 On matching ready at edge m: at m+1 Result=ModifiedText, owner Ry pulses one cycle, unit enable drops, state RELEASE, LastOwner=Owner.
REQ-011 BUSY cycle counter SHALL start at 0 on entry; reaching TIMEOUT without ready: Err pulses, enable drops, no Ry, state RELEASE.
REQ-012 Ready and timeout on the same edge: ready wins, no Err.
REQ-013 RELEASE SHALL hold until owner's En is all zero, then IDLE; the other requester waits (4-phase handshake).
REQ-014 Request changes from the owner during BUSY SHALL be ignored.
REQ-015 Grant-to-enable latency SHALL be 1 cycle; minimum back-to-back turnaround 3 cycles.

Reset
REQ-016 Rst low SHALL asynchronously force IDLE, all enables/Ry/Err/Busy/Owner 0, Result 0, counter 0, LastOwner=1 (encryptor wins first tie).
REQ-017 Reset mid-BUSY SHALL drop the unit enable immediately; no Ry or Err is produced.

Structure
REQ-018 Package aes_pkg SHALL hold WIDTH, op one-hot constants (ADD=0001, SUB=0010, SHIFT=0100, MIX=1000) and the FSM state type.
REQ-019 The two-way round-robin picker SHALL be sub-module rr_arbiter2; all else inline.

Verification
REQ-020 EncEn=0001, EncText=0x00112233..FF; AddRy at 3rd BUSY cycle, ModifiedText=0xA5..A5 -> AddEn 1 cycle after request, EncRy 1 cycle, Result=0xA5..A5.
REQ-021 EncEn=0100, DecEn=0010 same cycle after reset -> encryptor first; after EncEn drop, decryptor gets SubEn; next tie -> encryptor.
REQ-022 DecEn=0011 -> Err pulse, no enables, DecRy stays 0, RELEASE until DecEn=0.
REQ-023 MixEn owner, only AddRy asserted, TIMEOUT=8 -> Err at BUSY cycle 8, no Ry, MixEn drops.
REQ-024 Rst low in BUSY -> ShiftEn, Busy 0 asynchronously; after release EncEn=0001 -> grant to encryptor.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES shared-unit arbiter.
package aes_pkg;

  localparam int WIDTH = 128;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SHIFT = 4'b0100;
  localparam logic [3:0] OP_MIX   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/aes_unit_arbiter_if.sv
// Requester / shared-unit bus seen by the arbiter (slave) and its environment (master).
interface aes_unit_arbiter_if #(
  parameter int WIDTH = 128
);
  logic [3:0]       EncEn;
  logic [WIDTH-1:0] EncText;
  logic [3:0]       DecEn;
  logic [WIDTH-1:0] DecText;
  logic             AddEn;
  logic             SubEn;
  logic             ShiftEn;
  logic             MixEn;
  logic [WIDTH-1:0] Text;
  logic             AddRy;
  logic             SubRy;
  logic             ShiftRy;
  logic             MixRy;
  logic [WIDTH-1:0] ModifiedText;
  logic             EncRy;
  logic             DecRy;
  logic [WIDTH-1:0] Result;
  logic             Owner;
  logic             Busy;
  logic             Err;

  modport slave (
    input  EncEn, EncText, DecEn, DecText,
    input  AddRy, SubRy, ShiftRy, MixRy, ModifiedText,
    output AddEn, SubEn, ShiftEn, MixEn, Text,
    output EncRy, DecRy, Result, Owner, Busy, Err
  );

  modport master (
    output EncEn, EncText, DecEn, DecText,
    output AddRy, SubRy, ShiftRy, MixRy, ModifiedText,
    input  AddEn, SubEn, ShiftEn, MixEn, Text,
    input  EncRy, DecRy, Result, Owner, Busy, Err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie the requester that did not own last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Grant selection
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/aes_unit_arbiter.sv
// Arbitrates encryptor/decryptor access to the shared Add/Sub/Shift/Mix units,
// one operation per grant, with illegal-op and ready-timeout error reporting.
module aes_unit_arbiter #(
  parameter int WIDTH   = aes_pkg::WIDTH,
  parameter int TIMEOUT = 255
) (
  input logic               Clk,
  input logic               Rst,
  aes_unit_arbiter_if.slave bus
);
  import aes_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             last_owner;
  logic [7:0]       cnt;

  logic [3:0]       en;
  logic [3:0]       en_nxt;
  logic             enc_ry;
  logic             enc_ry_nxt;
  logic             dec_ry;
  logic             dec_ry_nxt;
  logic             err;
  logic             err_nxt;
  logic             busy;
  logic             busy_nxt;

  logic [1:0]       req;
  logic             gnt_valid;
  logic             gnt_id;
  logic [3:0]       gnt_op;
  logic [WIDTH-1:0] gnt_text;
  logic             gnt_legal;
  logic [3:0]       owner_en;
  logic [3:0]       rdy;
  logic             hit;
  logic             expired;

  rr_arbiter2 u_rr (
    .req       (req),
    .last      (last_owner),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Request decode, grant operand mux and ready/timeout qualification
  always_comb begin
    req       = {(bus.DecEn != 4'b0000), (bus.EncEn != 4'b0000)};
    gnt_op    = gnt_id ? bus.DecEn : bus.EncEn;
    gnt_text  = gnt_id ? bus.DecText : bus.EncText;
    gnt_legal = is_onehot4(gnt_op);
    owner_en  = owner ? bus.DecEn : bus.EncEn;
    rdy       = {bus.MixRy, bus.ShiftRy, bus.SubRy, bus.AddRy};
    // Only the ready of the latched op counts; stray readies are ignored.
    hit       = ((op & rdy) != 4'b0000);
    expired   = (cnt == CNT_LAST);
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_nxt = gnt_legal ? ST_BUSY : ST_RELEASE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (hit || expired) begin
          state_nxt = ST_RELEASE;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_RELEASE: begin
        if (owner_en == 4'b0000) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RELEASE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant latch, BUSY cycle counter and result capture
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      owner      <= 1'b0;
      op         <= 4'b0000;
      operand    <= '0;
      result     <= '0;
      last_owner <= 1'b1;
      cnt        <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner   <= gnt_id;
            op      <= gnt_op;
            operand <= gnt_text;
            cnt     <= 8'd0;
          end
        end
        ST_BUSY: begin
          if (hit) begin
            result     <= bus.ModifiedText;
            last_owner <= owner;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode, computed one cycle ahead so every output is a flop
  always_comb begin
    en_nxt     = 4'b0000;
    enc_ry_nxt = 1'b0;
    dec_ry_nxt = 1'b0;
    err_nxt    = 1'b0;
    busy_nxt   = (state_nxt != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (gnt_valid && gnt_legal) begin
          en_nxt = gnt_op;
        end else begin
          err_nxt = gnt_valid;
        end
      end
      ST_BUSY: begin
        if (hit) begin
          enc_ry_nxt = ~owner;
          dec_ry_nxt = owner;
        end else if (expired) begin
          err_nxt = 1'b1;
        end else begin
          en_nxt = op;
        end
      end
      default: begin
        en_nxt = 4'b0000;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      en     <= 4'b0000;
      enc_ry <= 1'b0;
      dec_ry <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      en     <= en_nxt;
      enc_ry <= enc_ry_nxt;
      dec_ry <= dec_ry_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
    end
  end

  assign bus.AddEn   = en[0];
  assign bus.SubEn   = en[1];
  assign bus.ShiftEn = en[2];
  assign bus.MixEn   = en[3];
  assign bus.Text    = operand;
  assign bus.Result  = result;
  assign bus.Owner   = owner;
  assign bus.Busy    = busy;
  assign bus.Err     = err;
  assign bus.EncRy   = enc_ry;
  assign bus.DecRy   = dec_ry;

endmodule
